alu_md_unit: RTL



---
 rtl/alu_md_pkg.sv | 39 +++
 rtl/alu_md_unit_div.sv | 72 +++++++
 rtl/alu_md_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_md_pkg.sv
// Shared types for the RV32IM execute unit: base ALU codes, M-extension funct3 codes,
// controller states and the op bit that selects the M group.
package alu_md_pkg;

  localparam int M_SEL_BIT = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_LUI  = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_md_unit_div.sv
// Radix-2 restoring divider on operand magnitudes with a final sign fix-up, plus
// detection of the divide-by-zero and signed-overflow cases that bypass iteration.
module div_iter
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            special,
  output logic [XLEN-1:0] special_q,
  output logic [XLEN-1:0] special_r,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_r, quot_r, dsr_r;
  logic            neg_q, neg_r;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_next, quot_next, abs_a, abs_b;
  logic            div_zero, most_neg;

  // done is asserted during the final iteration so the fixed-up result is ready on that edge
  always_comb begin
    abs_a     = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    abs_b     = (is_signed && divisor[XLEN-1]) ? -divisor : divisor;
    div_zero  = (divisor == '0);
    most_neg  = (dividend == {1'b1, {(XLEN-1){1'b0}}});
    special   = div_zero || (is_signed && most_neg && (divisor == '1));
    special_q = div_zero ? '1 : dividend;
    special_r = div_zero ? dividend : '0;
    shifted   = {rem_r, quot_r[XLEN-1]};
    diff      = shifted - {1'b0, dsr_r};
    rem_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quot_next = {quot_r[XLEN-2:0], ~diff[XLEN]};
    done      = (cnt == CW'(1));
    quotient  = neg_q ? -quot_next : quot_next;
    remainder = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      cnt    <= '0;
      rem_r  <= '0;
      quot_r <= '0;
      dsr_r  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      cnt    <= CW'(XLEN);
      rem_r  <= '0;
      quot_r <= abs_a;
      dsr_r  <= abs_b;
      neg_q  <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r  <= is_signed && dividend[XLEN-1];
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      rem_r  <= rem_next;
      quot_r <= quot_next;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// RV32IM execute unit: single-cycle base ALU, multi-cycle multiply and iterative divide,
// one op in flight behind valid/ready. Define ALU_MD_FLUSH_EN to add the flush port.
module alu_md_unit
  import alu_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
`ifdef ALU_MD_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);

  localparam int SHW = $clog2(XLEN);

  state_e            state;
  md_op_e            md_r, mul_f;
  logic [XLEN-1:0]   a_r, b_r, alu_res, mul_res, mul_a, mul_b;
  logic [2:0]        mul_cnt;
  logic              kill, accept, is_m, is_div, a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [SHW-1:0]    shamt;
  logic              div_special, div_done;
  logic [XLEN-1:0]   div_sq, div_sr, div_quot, div_rem;

`ifdef ALU_MD_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign in_ready = !kill && ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign is_m     = op[M_SEL_BIT];
  assign is_div   = is_m && op[2];

  always_comb begin
    shamt = rs2[SHW-1:0];
    case (op[3:0])
      ALU_ADD:  alu_res = rs1 + rs2;
      ALU_SUB:  alu_res = rs1 - rs2;
      ALU_SLL:  alu_res = rs1 << shamt;
      ALU_LUI:  alu_res = rs2;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
      ALU_XOR:  alu_res = rs1 ^ rs2;
      ALU_SRL:  alu_res = rs1 >> shamt;
      ALU_SRA:  alu_res = $signed(rs1) >>> shamt;
      ALU_OR:   alu_res = rs1 | rs2;
      ALU_AND:  alu_res = rs1 & rs2;
      default:  alu_res = '0;
    endcase
  end

  // Operands come straight from the inputs on accept, from the captured copy while in MUL
  always_comb begin
    mul_f   = (state == MUL) ? md_r : md_op_e'(op[2:0]);
    mul_a   = (state == MUL) ? a_r : rs1;
    mul_b   = (state == MUL) ? b_r : rs2;
    a_sgn   = (mul_f == MD_MULH) || (mul_f == MD_MULHSU);
    b_sgn   = (mul_f == MD_MULH);
    a_ext   = {{XLEN{a_sgn & mul_a[XLEN-1]}}, mul_a};
    b_ext   = {{XLEN{b_sgn & mul_b[XLEN-1]}}, mul_b};
    prod    = a_ext * b_ext;
    mul_res = (mul_f == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .abort     (kill),
    .start     (accept && is_div && !div_special),
    .is_signed (!op[0]),
    .dividend  (rs1),
    .divisor   (rs2),
    .special   (div_special),
    .special_q (div_sq),
    .special_r (div_sr),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // A new accept in DONE overrides the return to IDLE, so back-to-back ops see no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rd        <= '0;
      md_r      <= MD_MUL;
      a_r       <= '0;
      b_r       <= '0;
      mul_cnt   <= '0;
    end else if (kill) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            md_r <= md_op_e'(op[2:0]);
            a_r  <= rs1;
            b_r  <= rs2;
            if (!is_m) begin
              rd        <= alu_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (!op[2]) begin
              if (MUL_STAGES == 1) begin
                rd        <= mul_res;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                mul_cnt   <= 3'(MUL_STAGES - 2);
                out_valid <= 1'b0;
                state     <= MUL;
              end
            end else if (div_special) begin
              rd        <= op[1] ? div_sr : div_sq;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              out_valid <= 1'b0;
              state     <= DIV;
            end
          end
        end
        MUL: begin
          if (mul_cnt == 3'd0) begin
            rd        <= mul_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mul_cnt <= mul_cnt - 3'd1;
          end
        end
        DIV: begin
          if (div_done) begin
            rd        <= md_r[1] ? div_rem : div_quot;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
